branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences misprediction recovery and predictor training for the two-level (BHT/PHT) branch predictor.
- Sits at the M stage and consumes each resolved branch.
- Decides redirect PC and front-end flushes, including MIPS delay-slot keep and branch-likely annul.
- Queues table updates in a small FIFO so the predictor can take writes at its own pace.

Parameters:
- FIFO_DEPTH, 4: update-queue entries; power of two, ≥2.
- CNT_W, 16: width of the saturating mispredict counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- stallM  in  1  M stage frozen; resolution inputs ignored this cycle
- branchM  in  1  valid conditional branch in M
- branchL_M  in  1  branch in M is a branch-likely
- pred_takeM  in  1  prediction carried down from D
- actual_takeM  in  1  resolved direction
- pcM  in  32  branch PC
- targetM  in  32  resolved taken target
- ds_validE  in  1  a valid instruction (the branch's delay slot) occupies E this cycle
- redirect_ack  in  1  fetch accepted redirect_pc this cycle
- upd_ready  in  1  predictor accepts an update this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  correct-path PC
- flush_FD  out  1  flush F and D
- flush_E  out  1  flush E (annul delay slot)
- upd_valid  out  1  update entry available
- upd_pc  out  32  PC of update entry
- upd_taken  out  1  outcome of update entry
- stall_req  out  1  hold M; update FIFO full
- mispred_cnt  out  CNT_W  saturating count of recoveries

Behaviour:
- Reset (async, resetn=0): state IDLE; FIFO empty; all outputs 0; counter 0. Reset mid-recovery abandons it with no redirect.
- Accept: acc = branchM & ~stallM & ~fifo_full & (state==IDLE). Branches seen outside IDLE are wrong-path: no push, no recovery.
- Mispredict: mis = pred_takeM ^ actual_takeM.
- Annul: ann = branchL_M & ~actual_takeM.
- Correct PC: actual_takeM ? targetM : pcM+8, modulo 2^32; the delay slot is never re-fetched.
- Push: on acc, push {pcM, actual_takeM}.
- Pop: on upd_valid & upd_ready.
  - upd_valid = ~empty; upd_pc and upd_taken show the head entry, stable until popped.
  - Push and pop in the same cycle are both legal when not full; occupancy is unchanged.
  - When full, push is blocked even if a pop happens that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- stall_req = fifo_full (combinational). Upstream must keep the branch in M (stallM) until it is accepted.
- FSM:
  - IDLE: on acc & (mis|ann), latch redirect_pc and the ann flag, and increment mispred_cnt (saturates at all-ones).
    - Go to REDIR if ann | ds_validE; otherwise go to WAIT_DS.
  - WAIT_DS: delay slot not yet in E; no flush. On ds_validE, go to REDIR.
  - REDIR: redirect_valid=1, flush_FD=1, flush_E=ann flag. Hold until redirect_ack, then go to IDLE in the next cycle. redirect_pc is stable throughout.
- Latency: mispredict accepted at cycle t with ds present gives redirect_valid at t+1. With ack at t+1, IDLE at t+2.
- Outputs redirect_valid, flush_FD, flush_E are registered state decodes, with no combinational path from inputs.
- A correctly predicted non-likely branch touches only the FIFO and counts nothing.

Test Plan:
- Correct prediction: branchM=1, pred=act=1, pcM=0xBFC00100 → one FIFO entry {0xBFC00100,1}, redirect_valid stays 0, mispred_cnt=0.
- Mispredict not-taken→taken: pred=0, act=1, targetM=0x80001000, ds_validE=1 at t → t+1 redirect_valid=1, redirect_pc=0x80001000, flush_FD=1, flush_E=0. redirect_ack at t+3 → IDLE at t+4, mispred_cnt=1.
- Delay slot late: pred=1, act=0, pcM=0x80000010, ds_validE=0 for 3 cycles → WAIT_DS with no flush. ds_validE=1 → next cycle redirect_pc=0x80000018.
- Branch-likely not taken, pred=0: ann path, no wait even with ds_validE=0 → REDIR, flush_E=1, redirect_pc=pcM+8. Also pcM=0xFFFFFFFC → redirect_pc=0x00000004.
- FIFO back-pressure: upd_ready=0, five correct branches → stall_req=1 after the 4th push, 5th not accepted. One pop with the 5th held → 5th accepted the next cycle, order preserved. Simultaneous push/pop at occupancy 2 keeps occupancy 2.
- Async reset asserted in REDIR between edges → outputs 0 immediately; after release, IDLE with empty FIFO. Counter saturation: CNT_W=2, 4 mispredicts → mispred_cnt=3.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - M-stage branch resolution: redirect/flush sequencing and predictor update queue
module branch_resolve_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stallM,
  input  logic             branchM,
  input  logic             branchL_M,
  input  logic             pred_takeM,
  input  logic             actual_takeM,
  input  logic [31:0]      pcM,
  input  logic [31:0]      targetM,
  input  logic             ds_validE,
  input  logic             redirect_ack,
  input  logic             upd_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_FD,
  output logic             flush_E,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic             stall_req,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    REDIR   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_redirect_valid;
  logic                  r_flush_fd;
  logic                  r_flush_e;
  logic [31:0]           r_redirect_pc;
  logic                  r_ann;
  logic [CNT_W-1:0]      r_cnt;

  // Update queue: pointers carry one extra wrap bit to tell full from empty.
  logic [31:0]           r_fifo_pc [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_tk;
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_acc;
  logic                  w_mis;
  logic                  w_ann;
  logic                  w_recover;
  logic                  w_push;
  logic                  w_pop;
  logic [31:0]           w_corr_pc;
  logic [AW:0]           w_ptr_one;
  logic [CNT_W-1:0]      w_cnt_one;

  assign w_ptr_one = {{AW{1'b0}}, 1'b1};
  assign w_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Branches arriving while a recovery is in flight are on the wrong path and are dropped.
  assign w_acc     = branchM & ~stallM & ~w_full & (r_state == IDLE);
  assign w_mis     = pred_takeM ^ actual_takeM;
  assign w_ann     = branchL_M & ~actual_takeM;
  assign w_recover = w_acc & (w_mis | w_ann);
  // Fall-through skips the delay slot, which is kept (or annulled) in place.
  assign w_corr_pc = actual_takeM ? targetM : (pcM + 32'd8);

  assign w_push    = w_acc;
  assign w_pop     = ~w_empty & upd_ready;

  assign upd_valid = ~w_empty;
  assign upd_pc    = r_fifo_pc[r_rptr[AW-1:0]];
  assign upd_taken = r_fifo_tk[r_rptr[AW-1:0]];
  assign stall_req = w_full;

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush_FD       = r_flush_fd;
  assign flush_E        = r_flush_e;
  assign mispred_cnt    = r_cnt;

  // Queue storage: written at the tail on every accepted branch; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr[AW-1:0]] <= pcM;
      r_fifo_tk[r_wptr[AW-1:0]] <= actual_takeM;
    end
  end

  // Queue pointers advance independently, so push and pop may share a cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + w_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + w_ptr_one;
    end
  end

  // Recovery sequencer with registered redirect/flush outputs and saturating recovery count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= IDLE;
      r_redirect_valid <= 1'b0;
      r_flush_fd       <= 1'b0;
      r_flush_e        <= 1'b0;
      r_redirect_pc    <= '0;
      r_ann            <= 1'b0;
      r_cnt            <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_recover) begin
            r_redirect_pc <= w_corr_pc;
            r_ann         <= w_ann;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + w_cnt_one;
            // An annulled slot need not be waited for; otherwise the slot must reach E first.
            if (w_ann | ds_validE) begin
              r_state          <= REDIR;
              r_redirect_valid <= 1'b1;
              r_flush_fd       <= 1'b1;
              r_flush_e        <= w_ann;
            end else begin
              r_state <= WAIT_DS;
            end
          end
        end
        WAIT_DS: begin
          if (ds_validE) begin
            r_state          <= REDIR;
            r_redirect_valid <= 1'b1;
            r_flush_fd       <= 1'b1;
            r_flush_e        <= r_ann;
          end
        end
        REDIR: begin
          if (redirect_ack) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
            r_flush_fd       <= 1'b0;
            r_flush_e        <= 1'b0;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_redirect_valid <= 1'b0;
          r_flush_fd       <= 1'b0;
          r_flush_e        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        resetn;
  logic        stallM;
  logic        branchM;
  logic        branchL_M;
  logic        pred_takeM;
  logic        actual_takeM;
  logic [31:0] pcM;
  logic [31:0] targetM;
  logic        ds_validE;
  logic        redirect_ack;
  logic        upd_ready;

  logic        redirect_valid, flush_FD, flush_E, upd_valid, upd_taken, stall_req;
  logic [31:0] redirect_pc, upd_pc;
  logic [15:0] mispred_cnt;

  logic        d2_redirect_valid, d2_flush_FD, d2_flush_E, d2_upd_valid, d2_upd_taken, d2_stall_req;
  logic [31:0] d2_redirect_pc, d2_upd_pc;
  logic [1:0]  d2_mispred_cnt;

  int n_pass  = 0;
  int n_total = 0;

  branch_resolve_ctrl #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .stallM(stallM), .branchM(branchM), .branchL_M(branchL_M),
    .pred_takeM(pred_takeM), .actual_takeM(actual_takeM), .pcM(pcM), .targetM(targetM),
    .ds_validE(ds_validE), .redirect_ack(redirect_ack), .upd_ready(upd_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_FD(flush_FD),
    .flush_E(flush_E), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .stall_req(stall_req), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_ctrl #(.FIFO_DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .stallM(stallM), .branchM(branchM), .branchL_M(branchL_M),
    .pred_takeM(pred_takeM), .actual_takeM(actual_takeM), .pcM(pcM), .targetM(targetM),
    .ds_validE(ds_validE), .redirect_ack(redirect_ack), .upd_ready(upd_ready),
    .redirect_valid(d2_redirect_valid), .redirect_pc(d2_redirect_pc), .flush_FD(d2_flush_FD),
    .flush_E(d2_flush_E), .upd_valid(d2_upd_valid), .upd_pc(d2_upd_pc), .upd_taken(d2_upd_taken),
    .stall_req(d2_stall_req), .mispred_cnt(d2_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of outstanding updates and a recovery record.
  typedef struct {
    logic [31:0] pc;
    logic        tk;
  } ent_t;

  ent_t        q[$];
  bit          m_busy;      // a recovery has been accepted and not yet acknowledged
  bit          m_redir;     // the redirect request is being presented to fetch
  bit          m_ann;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_acc;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_busy  = 0;
      m_redir = 0;
      m_ann   = 0;
      m_pc    = '0;
      m_cnt   = 0;
    end else begin
      m_acc = branchM && !stallM && (q.size() < 4) && !m_busy;
      if (q.size() > 0 && upd_ready) void'(q.pop_front());
      if (m_acc) q.push_back('{pc: pcM, tk: actual_takeM});
      if (m_busy) begin
        if (m_redir) begin
          if (redirect_ack) begin
            m_busy  = 0;
            m_redir = 0;
          end
        end else if (ds_validE) begin
          m_redir = 1;
        end
      end else if (m_acc && ((pred_takeM != actual_takeM) || (branchL_M && !actual_takeM))) begin
        m_busy  = 1;
        m_ann   = branchL_M && !actual_takeM;
        m_pc    = actual_takeM ? targetM : pcM + 32'd8;
        m_redir = m_ann || ds_validE;
        m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
    chk("flush_FD", {31'd0, flush_FD}, {31'd0, m_redir});
    chk("flush_E", {31'd0, flush_E}, {31'd0, m_redir && m_ann});
    chk("upd_valid", {31'd0, upd_valid}, {31'd0, q.size() > 0});
    chk("stall_req", {31'd0, stall_req}, {31'd0, q.size() == 4});
    chk("mispred_cnt", {16'd0, mispred_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
    chk("d2_mispred_cnt", {30'd0, d2_mispred_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);
    chk("d2_redirect_valid", {31'd0, d2_redirect_valid}, {31'd0, m_redir});
    chk("d2_flush", {30'd0, d2_flush_FD, d2_flush_E}, {30'd0, m_redir, m_redir && m_ann});
    chk("d2_stall_req", {31'd0, d2_stall_req}, {31'd0, q.size() == 4});
    chk("d2_upd_valid", {31'd0, d2_upd_valid}, {31'd0, q.size() > 0});
    if (m_redir) begin
      chk("redirect_pc", redirect_pc, m_pc);
      chk("d2_redirect_pc", d2_redirect_pc, m_pc);
    end
    if (q.size() > 0) begin
      chk("upd_pc", upd_pc, q[0].pc);
      chk("upd_taken", {31'd0, upd_taken}, {31'd0, q[0].tk});
      chk("d2_upd", {d2_upd_pc[30:0], d2_upd_taken}, {q[0].pc[30:0], q[0].tk});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    branchM = 0; branchL_M = 0; pred_takeM = 0; actual_takeM = 0;
    ds_validE = 0; redirect_ack = 0; stallM = 0;
  endtask

  task automatic quick_mispredict();
    branchM = 1; branchL_M = 0; pred_takeM = 1; actual_takeM = 0; pcM = 32'h8000_0400; ds_validE = 1;
    cyc(1);
    branchM = 0; ds_validE = 0; redirect_ack = 1;
    cyc(1);
    redirect_ack = 0;
  endtask

  logic [31:0] exp_order [4];

  initial begin
    resetn = 0; upd_ready = 0; pcM = '0; targetM = '0;
    idle_inputs();
    cyc(2);
    chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("reset_cnt", {16'd0, mispred_cnt}, 32'd0);
    resetn = 1;
    cyc(1);

    // Correct prediction: queue only.
    branchM = 1; pred_takeM = 1; actual_takeM = 1; pcM = 32'hBFC0_0100;
    cyc(1);
    idle_inputs();
    chk("t1_upd_pc", upd_pc, 32'hBFC0_0100);
    chk("t1_upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("t1_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("t1_cnt", {16'd0, mispred_cnt}, 32'd0);
    upd_ready = 1;
    cyc(1);
    chk("t1_popped", {31'd0, upd_valid}, 32'd0);

    // Mispredict not-taken -> taken with slot present.
    branchM = 1; pred_takeM = 0; actual_takeM = 1; pcM = 32'h8000_0F00; targetM = 32'h8000_1000; ds_validE = 1;
    cyc(1);
    idle_inputs();
    chk("t2_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t2_pc", redirect_pc, 32'h8000_1000);
    chk("t2_fd_fe", {30'd0, flush_FD, flush_E}, 32'd2);
    cyc(2);
    chk("t2_rv_hold", {31'd0, redirect_valid}, 32'd1);
    redirect_ack = 1;
    cyc(1);
    redirect_ack = 0;
    chk("t2_idle_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t2_cnt", {16'd0, mispred_cnt}, 32'd1);

    // Delay slot late; a wrong-path branch during the wait is ignored.
    branchM = 1; pred_takeM = 1; actual_takeM = 0; pcM = 32'h8000_0010;
    cyc(1);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        branchM = 1; pred_takeM = 1; actual_takeM = 1; pcM = 32'hDEAD_0000;
      end
      chk("t3_wait_no_flush", {30'd0, redirect_valid, flush_FD}, 32'd0);
      cyc(1);
      idle_inputs();
    end
    chk("t3_wrong_path_dropped", {31'd0, upd_valid}, 32'd0);
    ds_validE = 1;
    cyc(1);
    ds_validE = 0;
    chk("t3_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t3_pc", redirect_pc, 32'h8000_0018);
    chk("t3_fe", {31'd0, flush_E}, 32'd0);
    redirect_ack = 1;
    cyc(1);
    redirect_ack = 0;

    // Branch-likely not taken: annul, no wait for the slot; then pc wrap.
    branchM = 1; branchL_M = 1; pred_takeM = 0; actual_takeM = 0; pcM = 32'h8000_2000;
    cyc(1);
    idle_inputs();
    chk("t4_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t4_fe", {31'd0, flush_E}, 32'd1);
    chk("t4_pc", redirect_pc, 32'h8000_2008);
    redirect_ack = 1;
    cyc(1);
    redirect_ack = 0;
    branchM = 1; branchL_M = 1; pred_takeM = 0; actual_takeM = 0; pcM = 32'hFFFF_FFFC;
    cyc(1);
    idle_inputs();
    chk("t4_wrap_pc", redirect_pc, 32'h0000_0004);
    chk("t4_wrap_fe", {31'd0, flush_E}, 32'd1);
    redirect_ack = 1;
    cyc(1);
    redirect_ack = 0;
    chk("t4_cnt", {16'd0, mispred_cnt}, 32'd4);

    // Back-pressure: fill, block the fifth, pop once, fifth goes in next cycle.
    upd_ready = 0;
    for (int i = 0; i < 4; i++) begin
      branchM = 1; pred_takeM = 1; actual_takeM = 1; pcM = 32'h100 + 32'(i * 4);
      cyc(1);
    end
    chk("t5_full", {31'd0, stall_req}, 32'd1);
    pcM = 32'h110;
    cyc(1);
    chk("t5_blocked_head", upd_pc, 32'h100);
    upd_ready = 1;
    cyc(1);
    upd_ready = 0;
    chk("t5_after_pop_stall", {31'd0, stall_req}, 32'd0);
    chk("t5_after_pop_head", upd_pc, 32'h104);
    cyc(1);
    idle_inputs();
    chk("t5_fifth_in", {31'd0, stall_req}, 32'd1);
    exp_order[0] = 32'h104; exp_order[1] = 32'h108; exp_order[2] = 32'h10C; exp_order[3] = 32'h110;
    upd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_order", upd_pc, exp_order[i]);
      cyc(1);
    end
    chk("t5_drained", {31'd0, upd_valid}, 32'd0);

    // Simultaneous push/pop at occupancy 2.
    upd_ready = 0;
    branchM = 1; pred_takeM = 0; actual_takeM = 0; pcM = 32'h200;
    cyc(1);
    pcM = 32'h204;
    cyc(1);
    upd_ready = 1; pcM = 32'h208;
    cyc(1);
    upd_ready = 0; pcM = 32'h20C;
    cyc(1);
    chk("t6_occ3_not_full", {31'd0, stall_req}, 32'd0);
    pcM = 32'h210;
    cyc(1);
    idle_inputs();
    chk("t6_occ4_full", {31'd0, stall_req}, 32'd1);
    chk("t6_head", upd_pc, 32'h204);
    upd_ready = 1;
    cyc(4);

    // Asynchronous reset while in REDIR.
    upd_ready = 0;
    branchM = 1; pred_takeM = 1; actual_takeM = 1; pcM = 32'h300;
    cyc(1);
    pred_takeM = 0; pcM = 32'h304; targetM = 32'h9000_0000; ds_validE = 1;
    cyc(1);
    idle_inputs();
    chk("t7_in_redir", {31'd0, redirect_valid}, 32'd1);
    #2 resetn = 0;
    #1;
    chk("t7_async_rv", {29'd0, redirect_valid, flush_FD, flush_E}, 32'd0);
    chk("t7_async_fifo", {30'd0, upd_valid, stall_req}, 32'd0);
    chk("t7_async_cnt", {16'd0, mispred_cnt}, 32'd0);
    cyc(1);
    resetn = 1;
    upd_ready = 1;
    cyc(1);
    chk("t7_after_release", {30'd0, redirect_valid, upd_valid}, 32'd0);

    // Counter saturation on the narrow instance.
    for (int i = 0; i < 4; i++) quick_mispredict();
    chk("t8_sat_cnt2", {30'd0, d2_mispred_cnt}, 32'd3);
    chk("t8_cnt16", {16'd0, mispred_cnt}, 32'd4);
    quick_mispredict();
    chk("t8_sat_hold", {30'd0, d2_mispred_cnt}, 32'd3);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
